// File: rtl/insn_phase_sequencer.sv
// Multi-cycle phase sequencer for the RV32I core: fetch/decode/execute/memory/writeback with memory timeout and sticky traps.
// Optional retired-instruction counter (output instret) is built when INSTRET_COUNTER_EN is defined.
module insn_phase_sequencer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  code,
    input  logic        stall,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rd_we,
    output logic        retired,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state
`ifdef INSTRET_COUNTER_EN
    ,
    output logic [31:0] instret
`endif
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd7
    } state_e;

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            illegal_q, illegal_d;
    logic            bus_err_q, bus_err_d;

    logic mem_req_c, mem_we_c, mem_addr_sel_c, ir_we_c, pc_we_c, rd_we_c, retired_c;
    logic [8:0] cls;
    logic       code_legal;

    assign cls        = code[8:0];
    // exactly one class bit set and the reserved bit clear
    assign code_legal = !code[9] && (cls != 9'd0) && ((cls & (cls - 9'd1)) == 9'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        illegal_d      = illegal_q;
        bus_err_d      = bus_err_q;
        mem_req_c      = 1'b0;
        mem_we_c       = 1'b0;
        mem_addr_sel_c = 1'b0;
        ir_we_c        = 1'b0;
        pc_we_c        = 1'b0;
        rd_we_c        = 1'b0;
        retired_c      = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (stall) begin
                    cnt_d = '0;
                end else begin
                    mem_req_c = 1'b1;
                    if (mem_ready) begin
                        ir_we_c = 1'b1;
                        state_d = S_DECODE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = S_TRAP;
                        bus_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + TO_W'(1);
                    end
                end
            end
            S_DECODE: begin
                if (code_legal) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_EXECUTE: begin
                if (code[4]) begin
                    pc_we_c   = 1'b1;
                    retired_c = 1'b1;
                    state_d   = S_FETCH;
                end else if (code[8] || code[6]) begin
                    state_d = S_MEMORY;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                mem_req_c      = 1'b1;
                mem_addr_sel_c = 1'b1;
                mem_we_c       = code[6];
                if (mem_ready) begin
                    if (code[6]) begin
                        pc_we_c   = 1'b1;
                        retired_c = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S_WRITEBACK: begin
                rd_we_c   = 1'b1;
                pc_we_c   = 1'b1;
                retired_c = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // reset masks the decoded enables so nothing is written while it is held
    assign mem_req      = mem_req_c      & ~reset;
    assign mem_we       = mem_we_c       & ~reset;
    assign mem_addr_sel = mem_addr_sel_c & ~reset;
    assign ir_we        = ir_we_c        & ~reset;
    assign pc_we        = pc_we_c        & ~reset;
    assign rd_we        = rd_we_c        & ~reset;
    assign retired      = retired_c      & ~reset;
    assign illegal      = illegal_q;
    assign bus_err      = bus_err_q;
    assign state        = state_q;

`ifdef INSTRET_COUNTER_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret_q <= '0;
        end else if (retired_c) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_insn_phase_sequencer.sv
// Directed self-checking bench for insn_phase_sequencer; expectations are queued per cycle and checked by immediate assertions.
module tb_insn_phase_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  code = 10'h020;
    logic        stall = 1'b0;
    logic        mem_ready = 1'b1;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rd_we, retired, illegal, bus_err;
    logic [2:0]  state;
`ifdef INSTRET_COUNTER_EN
    logic [31:0] instret;
`endif

    always #5 clk = ~clk;

    insn_phase_sequencer #(.TIMEOUT(16), .TO_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .code         (code),
        .stall        (stall),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .rd_we        (rd_we),
        .retired      (retired),
        .illegal      (illegal),
        .bus_err      (bus_err),
        .state        (state)
`ifdef INSTRET_COUNTER_EN
        ,
        .instret      (instret)
`endif
    );

    localparam logic [8:0] B_REQ  = 9'h100;
    localparam logic [8:0] B_WE   = 9'h080;
    localparam logic [8:0] B_ASEL = 9'h040;
    localparam logic [8:0] B_IR   = 9'h020;
    localparam logic [8:0] B_PC   = 9'h010;
    localparam logic [8:0] B_RD   = 9'h008;
    localparam logic [8:0] B_RET  = 9'h004;
    localparam logic [8:0] B_ILL  = 9'h002;
    localparam logic [8:0] B_BERR = 9'h001;
    localparam logic [8:0] B_NONE = 9'h000;

    logic [11:0] obs;
    assign obs = {state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rd_we, retired, illegal, bus_err};

    logic [11:0] exp_q[$];
    string       tag_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned exp_instret = 0;

    task automatic check_head();
        logic [11:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_tests++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed st=%0d fl=%h expected st=%0d fl=%h", t, obs[11:9], obs[8:0], e[11:9], e[8:0]);
        end
    endtask

    task automatic check_instret(input string t);
`ifdef INSTRET_COUNTER_EN
        n_tests++;
        assert (instret === exp_instret) else begin
            n_fail++;
            $error("FAIL %s: observed instret=%0d expected %0d", t, instret, exp_instret);
        end
`else
        if (t.len() < 0) $display("%s", t);
`endif
    endtask

    // One clock cycle: drive inputs, queue expectation, sample mid-cycle, advance past the edge
    task automatic step(input logic [9:0] c, input logic s, input logic r,
                        input logic [2:0] est, input logic [8:0] efl, input string t);
        code      = c;
        stall     = s;
        mem_ready = r;
        exp_q.push_back({est, efl});
        tag_q.push_back(t);
        #2;
        check_head();
        @(posedge clk);
        #1;
        if ((efl & B_RET) != 9'd0) exp_instret++;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        stall     = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #3;
        exp_q.push_back({3'd0, B_NONE});
        tag_q.push_back("reset_hold");
        check_head();
        @(posedge clk);
        #1;
        reset       = 1'b0;
        exp_instret = 0;
    endtask

    logic [9:0] ill_codes [3];

    initial begin
        ill_codes[0] = 10'h000;
        ill_codes[1] = 10'h030;
        ill_codes[2] = 10'h200;

        // 1: R-type with zero wait states
        do_reset();
        check_instret("instret_reset");
        step(10'h020, 0, 1, 3'd0, B_REQ | B_IR, "r_fetch");
        step(10'h020, 0, 1, 3'd1, B_NONE, "r_decode");
        step(10'h020, 0, 1, 3'd2, B_NONE, "r_execute");
        step(10'h020, 0, 1, 3'd4, B_RD | B_PC | B_RET, "r_writeback");
        step(10'h020, 0, 1, 3'd0, B_REQ | B_IR, "r_next_fetch");

        // 2: load with three wait states in MEMORY
        do_reset();
        step(10'h100, 0, 1, 3'd0, B_REQ | B_IR, "ld_fetch");
        step(10'h100, 0, 1, 3'd1, B_NONE, "ld_decode");
        step(10'h100, 0, 1, 3'd2, B_NONE, "ld_execute");
        for (int i = 0; i < 3; i++) step(10'h100, 0, 0, 3'd3, B_REQ | B_ASEL, "ld_mem_wait");
        step(10'h100, 0, 1, 3'd3, B_REQ | B_ASEL, "ld_mem_ready");
        step(10'h100, 0, 1, 3'd4, B_RD | B_PC | B_RET, "ld_writeback");

        // 3: store then branch back-to-back
        do_reset();
        step(10'h040, 0, 1, 3'd0, B_REQ | B_IR, "st_fetch");
        step(10'h040, 0, 1, 3'd1, B_NONE, "st_decode");
        step(10'h040, 0, 1, 3'd2, B_NONE, "st_execute");
        step(10'h040, 0, 1, 3'd3, B_REQ | B_WE | B_ASEL | B_PC | B_RET, "st_memory");
        step(10'h010, 0, 1, 3'd0, B_REQ | B_IR, "br_fetch");
        step(10'h010, 0, 1, 3'd1, B_NONE, "br_decode");
        step(10'h010, 0, 1, 3'd2, B_PC | B_RET, "br_execute");
        step(10'h010, 0, 1, 3'd0, B_REQ | B_IR, "br_next_fetch");
        check_instret("instret_two");

        // 4: illegal codes trap after DECODE and stay there
        foreach (ill_codes[k]) begin
            do_reset();
            step(ill_codes[k], 0, 1, 3'd0, B_REQ | B_IR, "ill_fetch");
            step(ill_codes[k], 0, 1, 3'd1, B_NONE, "ill_decode");
            for (int i = 0; i < 20; i++)
                step(ill_codes[k], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'd7, B_ILL, "ill_trap");
            do_reset();
            step(10'h020, 0, 0, 3'd0, B_REQ, "ill_cleared");
        end

        // 5a: FETCH timeout after 16 request cycles
        do_reset();
        for (int i = 0; i < 16; i++) step(10'h020, 0, 0, 3'd0, B_REQ, "to_wait");
        for (int i = 0; i < 3; i++) step(10'h020, 0, 1, 3'd7, B_BERR, "to_trap");
        // 5b: ready on the last allowed cycle wins
        do_reset();
        for (int i = 0; i < 15; i++) step(10'h020, 0, 0, 3'd0, B_REQ, "to_wait2");
        step(10'h020, 0, 1, 3'd0, B_REQ | B_IR, "to_last_ready");
        step(10'h020, 0, 1, 3'd1, B_NONE, "to_decode");

        // 6: stall, two retirements, then reset mid-MEMORY
        do_reset();
        for (int i = 0; i < 5; i++) step(10'h020, 1, 1, 3'd0, B_NONE, "stall_fetch");
        step(10'h020, 0, 1, 3'd0, B_REQ | B_IR, "s6_r_fetch");
        step(10'h020, 0, 1, 3'd1, B_NONE, "s6_r_decode");
        step(10'h020, 0, 1, 3'd2, B_NONE, "s6_r_execute");
        step(10'h020, 0, 1, 3'd4, B_RD | B_PC | B_RET, "s6_r_wb");
        step(10'h010, 0, 1, 3'd0, B_REQ | B_IR, "s6_br_fetch");
        step(10'h010, 0, 1, 3'd1, B_NONE, "s6_br_decode");
        step(10'h010, 0, 1, 3'd2, B_PC | B_RET, "s6_br_execute");
        step(10'h100, 0, 1, 3'd0, B_REQ | B_IR, "s6_ld_fetch");
        step(10'h100, 0, 1, 3'd1, B_NONE, "s6_ld_decode");
        step(10'h100, 0, 1, 3'd2, B_NONE, "s6_ld_execute");
        step(10'h100, 0, 0, 3'd3, B_REQ | B_ASEL, "s6_ld_mem");
        check_instret("instret_before_abort");
        // reset asserted between edges must clear state and outputs immediately
        mem_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        exp_q.push_back({3'd0, B_NONE});
        tag_q.push_back("async_reset");
        check_head();
        exp_instret = 0;
        check_instret("instret_after_abort");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(10'h020, 0, 1, 3'd0, B_REQ | B_IR, "resume_fetch");
        step(10'h020, 0, 1, 3'd1, B_NONE, "resume_decode");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
